// File: rtl/remote_cmd_pkg.sv
// Shared types and constants for the remote command queue.
package remote_cmd_pkg;

    // Sender FSM states: idle, strobe one byte, wait for the byte to finish,
    // wait for the one-byte response.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TX        = 2'd1,
        WAIT_DONE = 2'd2,
        WAIT_RESP = 2'd3
    } state_e;

    // Conventional positive acknowledge byte returned by the remote end.
    localparam logic [7:0] RESP_ACK = 8'hA5;

endpackage

// File: rtl/cmd_fifo.sv
// Circular command FIFO with wrapping pointers. A push into a full FIFO is
// ignored even when a pop happens in the same cycle; a pop from an empty
// FIFO is ignored.
module cmd_fifo #(
    parameter int CMD_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [CMD_W-1:0]         wdata_i,
    output logic [CMD_W-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   cnt_o
);
    localparam int AW = $clog2(DEPTH);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign cnt_o   = cnt_q;

    // Fullness is judged on the registered count, before any same-cycle pop.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok)      cnt_d = cnt_q + (AW+1)'(1);
        else if (!push_ok && pop_ok) cnt_d = cnt_q - (AW+1)'(1);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/remote_cmd_queue.sv
// Queues multi-byte commands and sends each MSB byte first over a byte-level
// UART handshake, then waits for a one-byte response with a timeout and an
// optional number of automatic retransmissions.
//
// Handshakes: a command is taken on every clock where send_cmd is high
// (no back-pressure; a full FIFO drops it and pulses ovf). Towards the UART,
// trmt is a one-cycle strobe qualifying tx_data, and the next byte is not
// offered until tx_done is seen. rx_rdy is a level that stays high until
// this block answers with a one-cycle clr_rx_rdy; a byte is consumed only
// on the first cycle it is seen, so a still-high rx_rdy during the clear
// is never taken twice.
module remote_cmd_queue
    import remote_cmd_pkg::*;
#(
    parameter int CMD_W       = 16,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int RETRIES     = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CMD_W-1:0]       cmd,
    input  logic                   send_cmd,
    output logic [7:0]             tx_data,
    output logic                   trmt,
    input  logic                   tx_done,
    input  logic [7:0]             rx_data,
    input  logic                   rx_rdy,
    output logic                   clr_rx_rdy,
    output logic                   cmd_sent,
    output logic [7:0]             resp,
    output logic                   resp_rdy,
    output logic                   timeout,
    output logic                   ovf,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] q_cnt
);
    localparam int CMD_BYTES = CMD_W / 8;
    localparam int BW = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

    state_e           state_q, state_d;
    logic [CMD_W-1:0] hold_q, hold_d;
    logic [CMD_W-1:0] shift_q, shift_d;
    logic [BW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [RW-1:0]    retry_cnt_q, retry_cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       resp_q, resp_d;
    logic             trmt_q, trmt_d;
    logic             cmd_sent_q, cmd_sent_d;
    logic             resp_rdy_q, resp_rdy_d;
    logic             timeout_q, timeout_d;
    logic             clr_rx_rdy_q, clr_rx_rdy_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;

    logic             fifo_pop;
    logic             fifo_full, fifo_empty;
    logic [CMD_W-1:0] fifo_rdata;
    logic             rx_new;
    logic             last_byte, timer_expired, retry_left;

    cmd_fifo #(
        .CMD_W (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (send_cmd),
        .pop_i   (fifo_pop),
        .wdata_i (cmd),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .cnt_o   (q_cnt)
    );

    // A byte counts as new only if it is not the one currently being cleared.
    assign rx_new        = rx_rdy && !clr_rx_rdy_q;
    assign last_byte     = (byte_cnt_q == BW'(CMD_BYTES - 1));
    assign timer_expired = (timer_q == TW'(TIMEOUT_CYC - 1));
    // retry_cnt never exceeds RETRIES, so inequality means retries remain.
    assign retry_left    = (retry_cnt_q != RW'(RETRIES));

    // Next-state, datapath and registered-output decode for the sender FSM.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        retry_cnt_d  = retry_cnt_q;
        timer_d      = timer_q;
        resp_d       = resp_q;
        tx_data_d    = tx_data_q;
        cmd_sent_d   = 1'b0;
        resp_rdy_d   = 1'b0;
        timeout_d    = 1'b0;
        fifo_pop     = 1'b0;
        // Any incoming byte is acknowledged; only WAIT_RESP keeps it.
        clr_rx_rdy_d = rx_new;
        ovf_d        = send_cmd && fifo_full;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    hold_d      = fifo_rdata;
                    shift_d     = fifo_rdata;
                    byte_cnt_d  = '0;
                    retry_cnt_d = '0;
                    state_d     = TX;
                end
            end
            TX: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    if (last_byte) begin
                        cmd_sent_d = 1'b1;
                        timer_d    = '0;
                        state_d    = WAIT_RESP;
                    end else begin
                        shift_d    = shift_q << 8;
                        byte_cnt_d = byte_cnt_q + BW'(1);
                        state_d    = TX;
                    end
                end
            end
            WAIT_RESP: begin
                timer_d = timer_q + TW'(1);
                if (rx_new) begin
                    resp_d     = rx_data;
                    resp_rdy_d = 1'b1;
                    state_d    = IDLE;
                end else if (timer_expired) begin
                    if (retry_left) begin
                        retry_cnt_d = retry_cnt_q + RW'(1);
                        shift_d     = hold_q;
                        byte_cnt_d  = '0;
                        state_d     = TX;
                    end else begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // trmt is registered against the state being entered, so it is high
        // exactly for the single cycle the FSM spends in TX.
        trmt_d = (state_d == TX);
        if (state_d == TX) tx_data_d = shift_d[CMD_W-1 -: 8];
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            retry_cnt_q  <= '0;
            timer_q      <= '0;
            tx_data_q    <= '0;
            resp_q       <= '0;
            trmt_q       <= 1'b0;
            cmd_sent_q   <= 1'b0;
            resp_rdy_q   <= 1'b0;
            timeout_q    <= 1'b0;
            clr_rx_rdy_q <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            timer_q      <= timer_d;
            tx_data_q    <= tx_data_d;
            resp_q       <= resp_d;
            trmt_q       <= trmt_d;
            cmd_sent_q   <= cmd_sent_d;
            resp_rdy_q   <= resp_rdy_d;
            timeout_q    <= timeout_d;
            clr_rx_rdy_q <= clr_rx_rdy_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign trmt       = trmt_q;
    assign clr_rx_rdy = clr_rx_rdy_q;
    assign cmd_sent   = cmd_sent_q;
    assign resp       = resp_q;
    assign resp_rdy   = resp_rdy_q;
    assign timeout    = timeout_q;
    assign ovf        = ovf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_remote_cmd_queue.sv
// Bench for remote_cmd_queue: a UART byte model answers each trmt with
// tx_done after a fixed delay, a monitor collects transmitted bytes and
// pulse counts, and each command is checked against its own MSB-first byte
// split, the chosen response behaviour and the timeout rules.
module tb_remote_cmd_queue;
    import remote_cmd_pkg::*;

    localparam int CMD_W = 16;
    localparam int NB    = CMD_W / 8;
    localparam int DEPTH = 4;
    localparam int TO    = 50;
    localparam int RET   = 1;
    localparam int TXD   = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [CMD_W-1:0]       cmd = '0;
    logic                   send_cmd = 1'b0;
    logic [7:0]             tx_data;
    logic                   trmt;
    logic                   tx_done;
    logic [7:0]             rx_data = '0;
    logic                   rx_rdy = 1'b0;
    logic                   clr_rx_rdy, cmd_sent, resp_rdy, timeout, ovf, busy;
    logic [7:0]             resp;
    logic [$clog2(DEPTH):0] q_cnt;

    remote_cmd_queue #(
        .CMD_W(CMD_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TO), .RETRIES(RET)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .send_cmd(send_cmd),
        .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
        .cmd_sent(cmd_sent), .resp(resp), .resp_rdy(resp_rdy),
        .timeout(timeout), .ovf(ovf), .busy(busy), .q_cnt(q_cnt)
    );

    // Second instance: 24-bit commands, no retries, short timeout.
    logic [23:0] b_cmd = '0;
    logic        b_send = 1'b0;
    logic [7:0]  b_tx_data, b_resp;
    logic        b_trmt, b_tx_done, b_clr, b_cmd_sent, b_resp_rdy, b_timeout, b_ovf, b_busy;
    logic [7:0]  b_rx_data = '0;
    logic        b_rx_rdy = 1'b0;
    logic [1:0]  b_q_cnt;

    remote_cmd_queue #(
        .CMD_W(24), .DEPTH(2), .TIMEOUT_CYC(30), .RETRIES(0)
    ) dut24 (
        .clk(clk), .rst_n(rst_n), .cmd(b_cmd), .send_cmd(b_send),
        .tx_data(b_tx_data), .trmt(b_trmt), .tx_done(b_tx_done),
        .rx_data(b_rx_data), .rx_rdy(b_rx_rdy), .clr_rx_rdy(b_clr),
        .cmd_sent(b_cmd_sent), .resp(b_resp), .resp_rdy(b_resp_rdy),
        .timeout(b_timeout), .ovf(b_ovf), .busy(b_busy), .q_cnt(b_q_cnt)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int n_sent = 0, n_rr = 0, n_to = 0, n_ovf = 0;
    int q_peak = 0;
    int rst_gen = 0;
    logic hold_tx = 1'b0;
    logic p_trmt = 0, p_sent = 0, p_rr = 0, p_to = 0, p_ovf = 0, p_clr = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- UART models ----------------
    initial begin : uart_tx_model
        int gen;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (trmt === 1'b1) begin
                gen = rst_gen;
                while (hold_tx) @(posedge clk);
                repeat (TXD) @(posedge clk);
                #1;
                if (gen == rst_gen) begin
                    tx_done = 1'b1;
                    @(posedge clk);
                    #1 tx_done = 1'b0;
                end
            end
        end
    end

    initial begin : uart_b_model
        b_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (b_trmt === 1'b1) begin
                repeat (TXD) @(posedge clk);
                #1 b_tx_done = 1'b1;
                @(posedge clk);
                #1 b_tx_done = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (trmt) begin
            got_q.push_back(tx_data);
            check_eq("trmt_width", 32'(p_trmt), 0);
        end
        if (cmd_sent) begin n_sent++; check_eq("cmd_sent_width", 32'(p_sent), 0); end
        if (resp_rdy) begin n_rr++;   check_eq("resp_rdy_width", 32'(p_rr), 0); end
        if (timeout)  begin n_to++;   check_eq("timeout_width", 32'(p_to), 0); end
        if (ovf)      begin n_ovf++;  check_eq("ovf_width", 32'(p_ovf), 0); end
        if (clr_rx_rdy) check_eq("clr_width", 32'(p_clr), 0);
        if (int'(q_cnt) > q_peak) q_peak = int'(q_cnt);
        p_trmt = trmt; p_sent = cmd_sent; p_rr = resp_rdy;
        p_to = timeout; p_ovf = ovf; p_clr = clr_rx_rdy;
    end

    // ---------------- driver tasks ----------------
    task automatic check_quiet_outputs(input string tag);
        check_eq({tag, "_trmt"}, 32'(trmt), 0);
        check_eq({tag, "_tx_data"}, 32'(tx_data), 0);
        check_eq({tag, "_cmd_sent"}, 32'(cmd_sent), 0);
        check_eq({tag, "_resp"}, 32'(resp), 0);
        check_eq({tag, "_resp_rdy"}, 32'(resp_rdy), 0);
        check_eq({tag, "_timeout"}, 32'(timeout), 0);
        check_eq({tag, "_ovf"}, 32'(ovf), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_q_cnt"}, 32'(q_cnt), 0);
        check_eq({tag, "_clr"}, 32'(clr_rx_rdy), 0);
    endtask

    // Called at #1 after a posedge; pushes one command on the next edge.
    task automatic send(input logic [CMD_W-1:0] c);
        cmd = c;
        send_cmd = 1'b1;
        @(posedge clk);
        #1 send_cmd = 1'b0;
    endtask

    // Presents a received byte; the UART side clears rx_rdy on the edge
    // after clr_rx_rdy is seen.
    task automatic inject_rx(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(posedge clk);
        #1 check_eq("clr_rx_rdy", 32'(clr_rx_rdy), 1);
        @(posedge clk);
        #1 rx_rdy = 1'b0;
    endtask

    task automatic wait_evt(input int which, input int budget, input string tag, output int cyc);
        logic hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < budget) begin
            @(negedge clk);
            cyc++;
            case (which)
                0: hit = cmd_sent;
                1: hit = resp_rdy;
                default: hit = timeout;
            endcase
        end
        if (!hit) check_eq({"wait_", tag}, 0, 1);
    endtask

    task automatic check_bytes(input logic [CMD_W-1:0] c);
        logic [7:0] g;
        for (int i = NB - 1; i >= 0; i--) exp_q.push_back(c[i*8 +: 8]);
        while (exp_q.size() > 0) begin
            if (got_q.size() == 0) begin
                check_eq("tx_byte_present", 0, 1);
                exp_q.delete();
            end else begin
                g = got_q.pop_front();
                check_eq("tx_byte", 32'(g), 32'(exp_q.pop_front()));
            end
        end
    endtask

    // mode 0: answer the first attempt; 1: stay silent once, answer the
    // retransmission; 2: never answer (retransmit, then timeout).
    // dly < 0 picks a random response delay within the timeout window.
    task automatic run_cmd(input logic [CMD_W-1:0] c, input int mode, input logic [7:0] rb, input int dly);
        int cyc, attempts, rr0, d;
        logic [7:0] resp_before;
        attempts = (mode == 0) ? 1 : 1 + RET;
        rr0 = n_rr;
        for (int a = 0; a < attempts; a++) begin
            wait_evt(0, TO + NB * (TXD + 6) + 40, "cmd_sent", cyc);
            check_bytes(c);
        end
        if (mode != 2) begin
            d = (dly < 0) ? int'($urandom_range(0, TO - 1)) : dly;
            repeat (d) @(posedge clk);
            #1 inject_rx(rb);
            check_eq("resp", 32'(resp), 32'(rb));
            check_eq("resp_rdy_count", 32'(n_rr - rr0), 1);
        end else begin
            resp_before = resp;
            wait_evt(2, TO + 10, "timeout", cyc);
            check_eq("timeout_latency", 32'(cyc), 32'(TO));
            check_eq("resp_kept", 32'(resp), 32'(resp_before));
            check_eq("no_resp_rdy", 32'(n_rr - rr0), 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [CMD_W-1:0] cs[$];
        int k, acc, ovf0, sent0, rr0, cyc, bn;
        logic [7:0] b_bytes[4];
        logic hit;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_quiet_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single command: pop latency, first trmt, byte order, response
        send(16'h2000);
        @(negedge clk);
        check_eq("t1_qcnt_after_push", 32'(q_cnt), 1);
        check_eq("t1_trmt_not_yet", 32'(trmt), 0);
        @(negedge clk);
        check_eq("t1_trmt_first", 32'(trmt), 1);
        check_eq("t1_tx_data_first", 32'(tx_data), 32'h20);
        check_eq("t1_qcnt_popped", 32'(q_cnt), 0);
        check_eq("t1_busy", 32'(busy), 1);
        run_cmd(16'h2000, 0, RESP_ACK, -1);
        check_eq("t1_busy_done", 32'(busy), 0);

        // Three back-to-back commands
        q_peak = 0;
        rr0 = n_rr;
        send(16'h4BF1); send(16'h2000); send(16'h1234);
        run_cmd(16'h4BF1, 0, RESP_ACK, -1);
        run_cmd(16'h2000, 0, RESP_ACK, 0);
        run_cmd(16'h1234, 0, RESP_ACK, TO - 1);   // response on the expiry cycle wins
        check_eq("t2_q_peak", 32'(q_peak), 2);
        check_eq("t2_resp_rdy_total", 32'(n_rr - rr0), 3);

        // Overflow with transmission stalled
        hold_tx = 1'b1;
        q_peak = 0;
        ovf0 = n_ovf;
        for (int i = 0; i < DEPTH + 2; i++) send(CMD_W'(16'h0100 * (i + 1) + i));
        @(negedge clk);
        #1;
        check_eq("t3_ovf_count", 32'(n_ovf - ovf0), 1);
        check_eq("t3_q_cnt_full", 32'(q_cnt), 32'(DEPTH));
        hold_tx = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) run_cmd(CMD_W'(16'h0100 * (i + 1) + i), 0, 8'h3C, -1);
        check_eq("t3_q_peak", 32'(q_peak), 32'(DEPTH));
        check_eq("t3_fifo_drained", 32'(q_cnt), 0);

        // No response: retransmit once then timeout; then answer on retry
        send(16'hC0DE);
        run_cmd(16'hC0DE, 2, 8'h00, -1);
        send(16'h5A5A);
        run_cmd(16'h5A5A, 1, 8'h42, -1);

        // Stray byte while idle is cleared but not reported
        rr0 = n_rr;
        inject_rx(8'h77);
        check_eq("stray_resp_kept", 32'(resp), 32'h42);
        check_eq("stray_no_resp_rdy", 32'(n_rr - rr0), 0);
        check_eq("stray_busy", 32'(busy), 0);

        // Randomised bursts from an idle queue
        for (int r = 0; r < 8; r++) begin
            k = int'($urandom_range(1, DEPTH + 2));
            acc = (k > DEPTH + 1) ? DEPTH + 1 : k;
            cs.delete();
            for (int i = 0; i < k; i++) cs.push_back(CMD_W'($urandom));
            q_peak = 0;
            ovf0 = n_ovf;
            for (int i = 0; i < k; i++) send(cs[i]);
            @(negedge clk);
            #1;
            check_eq("rnd_ovf_count", 32'(n_ovf - ovf0), 32'(k - acc));
            for (int i = 0; i < acc; i++)
                run_cmd(cs[i], int'($urandom_range(0, 2)), 8'($urandom), -1);
            check_eq("rnd_q_peak", 32'(q_peak), 32'((k == 1) ? 1 : ((k - 1 > DEPTH) ? DEPTH : k - 1)));
            check_eq("rnd_idle", 32'(busy), 0);
        end

        // Reset during WAIT_DONE of byte 0
        sent0 = n_sent;
        send(16'h1111);
        send(16'h2222);
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            hit = trmt;
        end
        check_eq("rst_trmt_seen", 32'(hit), 1);
        @(posedge clk);
        #1 check_eq("rst_pre_q_cnt", 32'(q_cnt), 1);
        rst_gen++;
        rst_n = 1'b0;
        #1 check_quiet_outputs("midrst");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_eq("rst_no_cmd_sent", 32'(n_sent - sent0), 0);
        check_eq("rst_idle_q_cnt", 32'(q_cnt), 0);
        got_q.delete();
        send(16'hBEEF);
        run_cmd(16'hBEEF, 0, RESP_ACK, -1);

        // 24-bit instance: three bytes, no retry, then timeout
        b_cmd = 24'hABCDEF;
        b_send = 1'b1;
        @(posedge clk);
        #1 b_send = 1'b0;
        bn = 0;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (b_trmt && bn < 4) begin b_bytes[bn] = b_tx_data; bn++; end
            hit = b_cmd_sent;
        end
        check_eq("b_cmd_sent_seen", 32'(hit), 1);
        check_eq("b_bytes_before_sent", 32'(bn), 3);
        check_eq("b_byte0", 32'(b_bytes[0]), 32'hAB);
        check_eq("b_byte1", 32'(b_bytes[1]), 32'hCD);
        check_eq("b_byte2", 32'(b_bytes[2]), 32'hEF);
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (b_trmt) bn++;
            hit = b_timeout;
        end
        check_eq("b_timeout_latency", 32'(cyc), 30);
        check_eq("b_no_retransmit", 32'(bn), 3);
        check_eq("b_resp_unchanged", 32'(b_resp), 0);
        @(negedge clk);
        check_eq("b_idle", 32'(b_busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
